// File: rtl/sram_resp_pkg.sv
// Shared types, constants and helpers for the SRAM bus responder.
package sram_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S_RD,
    S_WR,
    M_RD,
    M_WR,
    RECOVER
  } state_e;

  localparam int unsigned ADDR_W   = 24;
  localparam int unsigned ROM_A_W  = 23;
  localparam int unsigned DQ_W     = 16;
  localparam int unsigned BYTE_W   = 8;

  localparam int unsigned RD_WAIT_DEF = 4;
  localparam int unsigned WR_WAIT_DEF = 4;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BYTE_W-1:0] data;
    logic              hit;
    logic              writable;
  } snes_req_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BYTE_W-1:0] data;
    logic              wr;
  } mcu_req_t;

  // Pick the byte lane addressed by byte-address bit 0.
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [DQ_W-1:0] dq16, input logic a0);
    return (a0 == LANE_HI) ? dq16[15:8] : dq16[7:0];
  endfunction

endpackage

// File: rtl/sram_cycle_timer.sv
// Loadable down-counter that sticks at zero; done_c flags the terminal count.
module sram_cycle_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/sram_responder.sv
// Runs async SRAM read/write cycles for SNES (priority) and MCU requests,
// with pulse latching, byte-lane selection and a one-cycle bus turnaround.
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int unsigned RD_WAIT = RD_WAIT_DEF,
  parameter int unsigned WR_WAIT = WR_WAIT_DEF,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SNES_RD_START,
  input  logic                SNES_WR_START,
  input  logic [ADDR_W-1:0]   SNES_ROM_ADDR,
  input  logic                SNES_ROM_HIT,
  input  logic                SNES_IS_WRITABLE,
  input  logic [BYTE_W-1:0]   SNES_DATA_IN,
  output logic [BYTE_W-1:0]   SNES_DATA_OUT,
  input  logic                MCU_RRQ,
  input  logic                MCU_WRQ,
  input  logic [ADDR_W-1:0]   MCU_ADDR,
  input  logic [BYTE_W-1:0]   MCU_DOUT,
  output logic [BYTE_W-1:0]   MCU_DIN,
  output logic                MCU_RDY,
  output logic [ROM_A_W-1:0]  ROM_A,
  output logic [DQ_W-1:0]     ROM_DQ_OUT,
  input  logic [DQ_W-1:0]     ROM_DQ_IN,
  output logic                ROM_DQ_OE,
  output logic                ROM_CE_N,
  output logic                ROM_OE_N,
  output logic                ROM_WE_N,
  output logic                ROM_BLE_N,
  output logic                ROM_BHE_N
);

  state_e              state_q, state_d;
  logic                s_rd_pend_q, s_rd_pend_d;
  logic                s_wr_pend_q, s_wr_pend_d;
  snes_req_t           s_req_q, s_req_d;
  logic                m_pend_q, m_pend_d;
  mcu_req_t            m_req_q, m_req_d;
  logic                m_active_q, m_active_d;
  logic                mcu_rdy_q, mcu_rdy_d;
  logic                cur_a0_q, cur_a0_d;
  logic [ROM_A_W-1:0]  rom_a_q, rom_a_d;
  logic [DQ_W-1:0]     dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                ble_n_q, ble_n_d;
  logic                bhe_n_q, bhe_n_d;
  logic [BYTE_W-1:0]   snes_dout_q, snes_dout_d;
  logic [BYTE_W-1:0]   mcu_din_q, mcu_din_d;

  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_val;
  logic [CNT_W-1:0]    tmr_cnt;
  logic                tmr_done_c;

  logic                go, go_wr, go_mcu, recover;
  logic [ADDR_W-1:0]   go_addr;
  logic [BYTE_W-1:0]   go_data;

  sram_cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt      (tmr_cnt),
    .done_c   (tmr_done_c)
  );

  // Next-state, strobe and request-latch logic.
  always_comb begin
    state_d     = state_q;
    s_rd_pend_d = s_rd_pend_q;
    s_wr_pend_d = s_wr_pend_q;
    s_req_d     = s_req_q;
    m_pend_d    = m_pend_q;
    m_req_d     = m_req_q;
    m_active_d  = m_active_q;
    mcu_rdy_d   = mcu_rdy_q;
    cur_a0_d    = cur_a0_q;
    rom_a_d     = rom_a_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = dq_oe_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    ble_n_d     = ble_n_q;
    bhe_n_d     = bhe_n_q;
    snes_dout_d = snes_dout_q;
    mcu_din_d   = mcu_din_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    go          = 1'b0;
    go_wr       = 1'b0;
    go_mcu      = 1'b0;
    recover     = 1'b0;
    go_addr     = s_req_q.addr;
    go_data     = s_req_q.data;

    case (state_q)
      IDLE: begin
        if (s_rd_pend_q) begin
          s_rd_pend_d = 1'b0;
          go          = s_req_q.hit;
        end else if (s_wr_pend_q) begin
          s_wr_pend_d = 1'b0;
          go          = s_req_q.hit && s_req_q.writable;
          go_wr       = 1'b1;
        end else if (m_pend_q) begin
          m_pend_d   = 1'b0;
          m_active_d = 1'b1;
          go         = 1'b1;
          go_wr      = m_req_q.wr;
          go_mcu     = 1'b1;
          go_addr    = m_req_q.addr;
          go_data    = m_req_q.data;
        end
      end
      S_RD, M_RD: begin
        if (tmr_done_c) begin
          if (state_q == S_RD) begin
            snes_dout_d = byte_sel(ROM_DQ_IN, cur_a0_q);
          end else begin
            mcu_din_d = byte_sel(ROM_DQ_IN, cur_a0_q);
          end
          recover = 1'b1;
        end
      end
      S_WR, M_WR: begin
        // WE_N is low while the counter steps through WR_WAIT..1.
        if (tmr_done_c) begin
          recover = 1'b1;
        end else begin
          we_n_d = (tmr_cnt < CNT_W'(2));
        end
      end
      RECOVER: begin
        if (tmr_done_c) begin
          state_d = IDLE;
          if (m_active_q) begin
            mcu_rdy_d  = 1'b1;
            m_active_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (go) begin
      tmr_load = 1'b1;
      rom_a_d  = go_addr[ADDR_W-1:1];
      cur_a0_d = go_addr[0];
      ce_n_d   = 1'b0;
      if (go_wr) begin
        state_d  = go_mcu ? M_WR : S_WR;
        tmr_val  = CNT_W'(WR_WAIT + 1);
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        ble_n_d  = (go_addr[0] != LANE_LO);
        bhe_n_d  = (go_addr[0] != LANE_HI);
        dq_oe_d  = 1'b1;
        dq_out_d = {go_data, go_data};
      end else begin
        state_d  = go_mcu ? M_RD : S_RD;
        tmr_val  = CNT_W'(RD_WAIT - 1);
        oe_n_d   = 1'b0;
        we_n_d   = 1'b1;
        ble_n_d  = 1'b0;
        bhe_n_d  = 1'b0;
        dq_oe_d  = 1'b0;
      end
    end

    if (recover) begin
      state_d  = RECOVER;
      tmr_load = 1'b1;
      tmr_val  = '0;
      ce_n_d   = 1'b1;
      oe_n_d   = 1'b1;
      we_n_d   = 1'b1;
      ble_n_d  = 1'b1;
      bhe_n_d  = 1'b1;
      dq_oe_d  = 1'b0;
    end

    // New pulses win over the clear done above; read beats a same-cycle write.
    if (SNES_RD_START) begin
      s_rd_pend_d = 1'b1;
      s_wr_pend_d = 1'b0;
      s_req_d     = '{addr: SNES_ROM_ADDR, data: SNES_DATA_IN,
                      hit: SNES_ROM_HIT, writable: SNES_IS_WRITABLE};
    end else if (SNES_WR_START) begin
      s_wr_pend_d = 1'b1;
      s_rd_pend_d = 1'b0;
      s_req_d     = '{addr: SNES_ROM_ADDR, data: SNES_DATA_IN,
                      hit: SNES_ROM_HIT, writable: SNES_IS_WRITABLE};
    end

    if (mcu_rdy_q && (MCU_RRQ || MCU_WRQ)) begin
      m_pend_d  = 1'b1;
      m_req_d   = '{addr: MCU_ADDR, data: MCU_DOUT, wr: !MCU_RRQ};
      mcu_rdy_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      s_rd_pend_q <= 1'b0;
      s_wr_pend_q <= 1'b0;
      s_req_q     <= '0;
      m_pend_q    <= 1'b0;
      m_req_q     <= '0;
      m_active_q  <= 1'b0;
      mcu_rdy_q   <= 1'b1;
      cur_a0_q    <= 1'b0;
      rom_a_q     <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ble_n_q     <= 1'b1;
      bhe_n_q     <= 1'b1;
      snes_dout_q <= '0;
      mcu_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      s_rd_pend_q <= s_rd_pend_d;
      s_wr_pend_q <= s_wr_pend_d;
      s_req_q     <= s_req_d;
      m_pend_q    <= m_pend_d;
      m_req_q     <= m_req_d;
      m_active_q  <= m_active_d;
      mcu_rdy_q   <= mcu_rdy_d;
      cur_a0_q    <= cur_a0_d;
      rom_a_q     <= rom_a_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      ble_n_q     <= ble_n_d;
      bhe_n_q     <= bhe_n_d;
      snes_dout_q <= snes_dout_d;
      mcu_din_q   <= mcu_din_d;
    end
  end

  assign SNES_DATA_OUT = snes_dout_q;
  assign MCU_DIN       = mcu_din_q;
  assign MCU_RDY       = mcu_rdy_q;
  assign ROM_A         = rom_a_q;
  assign ROM_DQ_OUT    = dq_out_q;
  assign ROM_DQ_OE     = dq_oe_q;
  assign ROM_CE_N      = ce_n_q;
  assign ROM_OE_N      = oe_n_q;
  assign ROM_WE_N      = we_n_q;
  assign ROM_BLE_N     = ble_n_q;
  assign ROM_BHE_N     = bhe_n_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder with a small behavioural 16-bit SRAM model.
module tb_sram_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        SNES_RD_START = 1'b0;
  logic        SNES_WR_START = 1'b0;
  logic [23:0] SNES_ROM_ADDR = '0;
  logic        SNES_ROM_HIT = 1'b0;
  logic        SNES_IS_WRITABLE = 1'b0;
  logic [7:0]  SNES_DATA_IN = '0;
  logic [7:0]  SNES_DATA_OUT;
  logic        MCU_RRQ = 1'b0;
  logic        MCU_WRQ = 1'b0;
  logic [23:0] MCU_ADDR = '0;
  logic [7:0]  MCU_DOUT = '0;
  logic [7:0]  MCU_DIN;
  logic        MCU_RDY;
  logic [22:0] ROM_A;
  logic [15:0] ROM_DQ_OUT;
  logic [15:0] ROM_DQ_IN;
  logic        ROM_DQ_OE;
  logic        ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_BLE_N, ROM_BHE_N;

  int n_checks = 0;
  int n_fail   = 0;

  sram_responder dut (
    .CLK              (CLK),
    .RST              (RST),
    .SNES_RD_START    (SNES_RD_START),
    .SNES_WR_START    (SNES_WR_START),
    .SNES_ROM_ADDR    (SNES_ROM_ADDR),
    .SNES_ROM_HIT     (SNES_ROM_HIT),
    .SNES_IS_WRITABLE (SNES_IS_WRITABLE),
    .SNES_DATA_IN     (SNES_DATA_IN),
    .SNES_DATA_OUT    (SNES_DATA_OUT),
    .MCU_RRQ          (MCU_RRQ),
    .MCU_WRQ          (MCU_WRQ),
    .MCU_ADDR         (MCU_ADDR),
    .MCU_DOUT         (MCU_DOUT),
    .MCU_DIN          (MCU_DIN),
    .MCU_RDY          (MCU_RDY),
    .ROM_A            (ROM_A),
    .ROM_DQ_OUT       (ROM_DQ_OUT),
    .ROM_DQ_IN        (ROM_DQ_IN),
    .ROM_DQ_OE        (ROM_DQ_OE),
    .ROM_CE_N         (ROM_CE_N),
    .ROM_OE_N         (ROM_OE_N),
    .ROM_WE_N         (ROM_WE_N),
    .ROM_BLE_N        (ROM_BLE_N),
    .ROM_BHE_N        (ROM_BHE_N)
  );

  always #5 CLK = ~CLK;

  // SRAM model: word 0x40 preloaded with 0x1234.
  logic [15:0] mem [0:255] = '{8'h40: 16'h1234, default: 16'h0000};

  assign ROM_DQ_IN = (!ROM_CE_N && !ROM_OE_N) ? mem[ROM_A[7:0]] : 16'hFFFF;

  always @(posedge CLK) begin
    if (!ROM_CE_N && !ROM_WE_N) begin
      if (!ROM_BLE_N) mem[ROM_A[7:0]][7:0]  <= ROM_DQ_OUT[7:0];
      if (!ROM_BHE_N) mem[ROM_A[7:0]][15:8] <= ROM_DQ_OUT[15:8];
    end
  end

  // Bus activity monitor, sampled mid-cycle.
  int          ce_cnt = 0, oe_cnt = 0, we_cnt = 0, we_bad = 0;
  logic [22:0] oe_a = '0, we_a = '0;
  logic [15:0] we_dq = '0;
  logic        we_ble = 1'b1, we_bhe = 1'b1;

  always @(negedge CLK) begin
    if (!ROM_CE_N) ce_cnt = ce_cnt + 1;
    if (!ROM_OE_N) begin
      oe_cnt = oe_cnt + 1;
      oe_a   = ROM_A;
    end
    if (!ROM_WE_N) begin
      we_cnt = we_cnt + 1;
      we_a   = ROM_A;
      we_dq  = ROM_DQ_OUT;
      we_ble = ROM_BLE_N;
      we_bhe = ROM_BHE_N;
      if (ROM_CE_N || !ROM_DQ_OE) we_bad = we_bad + 1;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_mcu_rdy(input string name);
    int k = 0;
    while (MCU_RDY !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    n_checks++;
    if (MCU_RDY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_rdy_timeout: MCU_RDY=%b after %0d cycles, required 1", name, MCU_RDY, k);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #2;
    n_checks++; if (ROM_CE_N !== 1'b1) begin n_fail++; $display("FAIL reset_ce_n: got %b want 1", ROM_CE_N); end
    n_checks++; if (ROM_OE_N !== 1'b1) begin n_fail++; $display("FAIL reset_oe_n: got %b want 1", ROM_OE_N); end
    n_checks++; if (ROM_WE_N !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %b want 1", ROM_WE_N); end
    n_checks++; if ({ROM_BLE_N, ROM_BHE_N} !== 2'b11) begin n_fail++; $display("FAIL reset_lanes: got %b want 11", {ROM_BLE_N, ROM_BHE_N}); end
    n_checks++; if (ROM_DQ_OE !== 1'b0) begin n_fail++; $display("FAIL reset_dq_oe: got %b want 0", ROM_DQ_OE); end
    n_checks++; if (ROM_A !== 23'h0) begin n_fail++; $display("FAIL reset_rom_a: got %h want 0", ROM_A); end
    n_checks++; if (ROM_DQ_OUT !== 16'h0) begin n_fail++; $display("FAIL reset_dq_out: got %h want 0", ROM_DQ_OUT); end
    n_checks++; if (SNES_DATA_OUT !== 8'h00) begin n_fail++; $display("FAIL reset_snes_data: got %h want 00", SNES_DATA_OUT); end
    n_checks++; if (MCU_DIN !== 8'h00) begin n_fail++; $display("FAIL reset_mcu_din: got %h want 00", MCU_DIN); end
    n_checks++; if (MCU_RDY !== 1'b1) begin n_fail++; $display("FAIL reset_mcu_rdy: got %b want 1", MCU_RDY); end
    RST = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_read;
    logic [23:0] addr;
    logic [7:0]  exp, prev;
    int          oe0;
    for (int i = 0; i < 2; i++) begin
      addr = (i == 0) ? 24'h000081 : 24'h000080;
      exp  = (i == 0) ? 8'h12 : 8'h34;
      prev = (i == 0) ? 8'h00 : 8'h12;
      oe0  = oe_cnt;
      SNES_ROM_ADDR = addr;
      SNES_ROM_HIT  = 1'b1;
      SNES_RD_START = 1'b1;
      tick();
      SNES_RD_START = 1'b0;
      repeat (4) tick();
      n_checks++; if (SNES_DATA_OUT !== prev) begin n_fail++; $display("FAIL read%0d_early: data %h at edge 5, want %h", i, SNES_DATA_OUT, prev); end
      tick();
      n_checks++; if (SNES_DATA_OUT !== exp) begin n_fail++; $display("FAIL read%0d_data: got %h want %h", i, SNES_DATA_OUT, exp); end
      n_checks++; if (oe_cnt - oe0 != 4) begin n_fail++; $display("FAIL read%0d_oe_cycles: got %0d want 4", i, oe_cnt - oe0); end
      n_checks++; if (oe_a !== 23'h000040) begin n_fail++; $display("FAIL read%0d_rom_a: got %h want 000040", i, oe_a); end
      repeat (3) tick();
    end
  endtask

  task automatic test_write_gating;
    int we0, ce0;
    we0 = we_cnt;
    SNES_ROM_ADDR    = 24'hE00003;
    SNES_DATA_IN     = 8'hA5;
    SNES_ROM_HIT     = 1'b1;
    SNES_IS_WRITABLE = 1'b1;
    SNES_WR_START    = 1'b1;
    tick();
    SNES_WR_START = 1'b0;
    repeat (12) tick();
    n_checks++; if (we_cnt - we0 != 4) begin n_fail++; $display("FAIL write_we_cycles: got %0d want 4", we_cnt - we0); end
    n_checks++; if ({we_ble, we_bhe} !== 2'b10) begin n_fail++; $display("FAIL write_lanes: ble/bhe got %b want 10", {we_ble, we_bhe}); end
    n_checks++; if (we_dq !== 16'hA5A5) begin n_fail++; $display("FAIL write_dq: got %h want a5a5", we_dq); end
    n_checks++; if (we_a !== 23'h700001) begin n_fail++; $display("FAIL write_rom_a: got %h want 700001", we_a); end
    n_checks++; if (we_bad != 0) begin n_fail++; $display("FAIL write_ce_dqoe: %0d WE-low cycles without CE/DQ_OE, want 0", we_bad); end
    n_checks++; if (mem[8'h01] !== 16'hA500) begin n_fail++; $display("FAIL write_mem: got %h want a500", mem[8'h01]); end
    for (int i = 0; i < 2; i++) begin
      ce0 = ce_cnt;
      SNES_ROM_HIT     = (i == 1) ? 1'b0 : 1'b1;
      SNES_IS_WRITABLE = (i == 1) ? 1'b1 : 1'b0;
      SNES_DATA_IN     = 8'h5C;
      SNES_WR_START    = 1'b1;
      tick();
      SNES_WR_START = 1'b0;
      repeat (10) tick();
      n_checks++; if (ce_cnt - ce0 != 0) begin n_fail++; $display("FAIL write_gated%0d: %0d CE cycles, want 0", i, ce_cnt - ce0); end
    end
    n_checks++; if (mem[8'h01] !== 16'hA500) begin n_fail++; $display("FAIL write_gated_mem: got %h want a500", mem[8'h01]); end
    SNES_ROM_HIT = 1'b1;
  endtask

  task automatic test_mcu_readback;
    MCU_ADDR = 24'hE00003;
    MCU_RRQ  = 1'b1;
    tick();
    MCU_RRQ = 1'b0;
    wait_mcu_rdy("readback");
    n_checks++; if (MCU_DIN !== 8'hA5) begin n_fail++; $display("FAIL readback_din: got %h want a5", MCU_DIN); end
    repeat (2) tick();
  endtask

  task automatic test_arbitration;
    int oe0;
    oe0 = oe_cnt;
    MCU_ADDR = 24'h000080;
    MCU_RRQ  = 1'b1;
    tick();
    MCU_RRQ = 1'b0;
    n_checks++; if (MCU_RDY !== 1'b0) begin n_fail++; $display("FAIL arb_rdy_fall: got %b want 0", MCU_RDY); end
    tick();
    SNES_ROM_ADDR = 24'h000081;
    SNES_ROM_HIT  = 1'b1;
    SNES_RD_START = 1'b1;
    tick();
    SNES_RD_START = 1'b0;
    repeat (3) tick();
    n_checks++; if (oe_cnt - oe0 != 4) begin n_fail++; $display("FAIL arb_mcu_oe: got %0d want 4", oe_cnt - oe0); end
    n_checks++; if ({ROM_CE_N, ROM_OE_N, MCU_RDY} !== 3'b110) begin n_fail++; $display("FAIL arb_recover: ce/oe/rdy got %b want 110", {ROM_CE_N, ROM_OE_N, MCU_RDY}); end
    tick();
    n_checks++; if (MCU_RDY !== 1'b1) begin n_fail++; $display("FAIL arb_rdy_rise: got %b want 1", MCU_RDY); end
    n_checks++; if (MCU_DIN !== 8'h34) begin n_fail++; $display("FAIL arb_mcu_din: got %h want 34", MCU_DIN); end
    tick();
    n_checks++; if ({ROM_OE_N, ROM_A} !== {1'b0, 23'h000040}) begin n_fail++; $display("FAIL arb_snes_start: oe_n/a got %b/%h want 0/000040", ROM_OE_N, ROM_A); end
    repeat (3) tick();
    n_checks++; if (SNES_DATA_OUT !== 8'h34) begin n_fail++; $display("FAIL arb_snes_early: got %h want 34", SNES_DATA_OUT); end
    tick();
    n_checks++; if (SNES_DATA_OUT !== 8'h12) begin n_fail++; $display("FAIL arb_snes_data: got %h want 12", SNES_DATA_OUT); end
    repeat (3) tick();
  endtask

  task automatic test_simultaneous;
    int we0, oe0;
    we0 = we_cnt;
    oe0 = oe_cnt;
    SNES_ROM_ADDR    = 24'h000080;
    SNES_DATA_IN     = 8'h77;
    SNES_ROM_HIT     = 1'b1;
    SNES_IS_WRITABLE = 1'b1;
    SNES_RD_START    = 1'b1;
    SNES_WR_START    = 1'b1;
    tick();
    SNES_RD_START = 1'b0;
    SNES_WR_START = 1'b0;
    repeat (12) tick();
    n_checks++; if (we_cnt - we0 != 0) begin n_fail++; $display("FAIL simul_we: %0d WE cycles, want 0", we_cnt - we0); end
    n_checks++; if (oe_cnt - oe0 != 4) begin n_fail++; $display("FAIL simul_oe: got %0d want 4", oe_cnt - oe0); end
    n_checks++; if (SNES_DATA_OUT !== 8'h34) begin n_fail++; $display("FAIL simul_data: got %h want 34", SNES_DATA_OUT); end
    n_checks++; if (mem[8'h40] !== 16'h1234) begin n_fail++; $display("FAIL simul_mem: got %h want 1234", mem[8'h40]); end
  endtask

  task automatic test_mcu_ignore;
    int we0;
    we0 = we_cnt;
    MCU_ADDR = 24'h000100;
    MCU_DOUT = 8'h5A;
    MCU_WRQ  = 1'b1;
    tick();
    MCU_WRQ = 1'b0;
    n_checks++; if (MCU_RDY !== 1'b0) begin n_fail++; $display("FAIL ignore_rdy_fall: got %b want 0", MCU_RDY); end
    MCU_ADDR = 24'h000102;
    MCU_DOUT = 8'hC3;
    MCU_WRQ  = 1'b1;
    tick();
    MCU_WRQ = 1'b0;
    wait_mcu_rdy("ignore");
    repeat (4) tick();
    n_checks++; if (we_cnt - we0 != 4) begin n_fail++; $display("FAIL ignore_we: got %0d WE cycles want 4", we_cnt - we0); end
    n_checks++; if (mem[8'h80] !== 16'h005A) begin n_fail++; $display("FAIL ignore_mem80: got %h want 005a", mem[8'h80]); end
    n_checks++; if (mem[8'h81] !== 16'h0000) begin n_fail++; $display("FAIL ignore_mem81: got %h want 0000", mem[8'h81]); end
  endtask

  task automatic test_reset_mid;
    int k, oe0;
    MCU_ADDR = 24'hE00002;
    MCU_DOUT = 8'h3C;
    MCU_WRQ  = 1'b1;
    tick();
    MCU_WRQ = 1'b0;
    k = 0;
    while (ROM_WE_N !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    n_checks++; if (ROM_WE_N !== 1'b0) begin n_fail++; $display("FAIL rstmid_we_low: WE_N=%b after %0d cycles, want 0", ROM_WE_N, k); end
    #2;
    RST = 1'b1;
    #1;
    n_checks++; if ({ROM_WE_N, ROM_CE_N, ROM_DQ_OE} !== 3'b110) begin n_fail++; $display("FAIL rstmid_strobes: we/ce/dqoe got %b want 110", {ROM_WE_N, ROM_CE_N, ROM_DQ_OE}); end
    n_checks++; if (MCU_RDY !== 1'b1) begin n_fail++; $display("FAIL rstmid_rdy: got %b want 1", MCU_RDY); end
    #2;
    RST = 1'b0;
    tick();
    tick();
    oe0 = oe_cnt;
    SNES_ROM_ADDR = 24'h000081;
    SNES_ROM_HIT  = 1'b1;
    SNES_RD_START = 1'b1;
    tick();
    SNES_RD_START = 1'b0;
    repeat (5) tick();
    n_checks++; if (SNES_DATA_OUT !== 8'h12) begin n_fail++; $display("FAIL rstmid_next_read: got %h want 12", SNES_DATA_OUT); end
    n_checks++; if (oe_cnt - oe0 != 4) begin n_fail++; $display("FAIL rstmid_next_oe: got %0d want 4", oe_cnt - oe0); end
    repeat (3) tick();
  endtask

  task automatic test_miss;
    int ce0;
    ce0 = ce_cnt;
    SNES_ROM_ADDR = 24'h000080;
    SNES_ROM_HIT  = 1'b0;
    SNES_RD_START = 1'b1;
    tick();
    SNES_RD_START = 1'b0;
    repeat (10) tick();
    n_checks++; if (ce_cnt - ce0 != 0) begin n_fail++; $display("FAIL miss_ce: %0d CE cycles, want 0", ce_cnt - ce0); end
    n_checks++; if (SNES_DATA_OUT !== 8'h12) begin n_fail++; $display("FAIL miss_data: got %h want 12", SNES_DATA_OUT); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_gating();
    test_mcu_readback();
    test_arbitration();
    test_simultaneous();
    test_mcu_ignore();
    test_reset_mid();
    test_miss();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Executes the external SRAM bus cycles for the translated addresses produced by the cartridge address mapper.
- Takes SNES read/write start pulses plus the mapped address and hit/writable flags, and MCU read/write requests; arbitrates between them (SNES first).
- Drives a 16-bit asynchronous SRAM with byte lanes and returns read bytes to the SNES data path or to the MCU.
- Sits between the address mapper and the SRAM pins in the top level.

Parameters:
- RD_WAIT, 4, cycles ROM_OE_N is held low before read data is captured (range 2..15)
- WR_WAIT, 4, cycles ROM_WE_N is held low during a write (range 2..15)
- CNT_W, 4, width of the cycle counter; must hold max(RD_WAIT, WR_WAIT)+1

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- SNES_RD_START  in  1  one-cycle pulse: SNES read strobe begun
- SNES_WR_START  in  1  one-cycle pulse: SNES write data valid
- SNES_ROM_ADDR  in  24  byte address from the mapper
- SNES_ROM_HIT  in  1  mapper: address backed by SRAM
- SNES_IS_WRITABLE  in  1  mapper: address may be written
- SNES_DATA_IN  in  8  SNES write byte
- SNES_DATA_OUT  out  8  last SNES read byte
- MCU_RRQ  in  1  one-cycle MCU read request
- MCU_WRQ  in  1  one-cycle MCU write request
- MCU_ADDR  in  24  MCU byte address
- MCU_DOUT  in  8  MCU write byte
- MCU_DIN  out  8  MCU read byte
- MCU_RDY  out  1  1 = MCU port idle / last access complete
- ROM_A  out  23  SRAM word address (byte address [23:1])
- ROM_DQ_OUT  out  16  write data, byte replicated on both lanes
- ROM_DQ_IN  in  16  SRAM read data
- ROM_DQ_OE  out  1  1 = FPGA drives DQ
- ROM_CE_N, ROM_OE_N, ROM_WE_N  out  1 each  SRAM strobes, active-low
- ROM_BLE_N, ROM_BHE_N  out  1 each  lane enables; address bit 0 = 0 selects low lane, 1 selects high lane

Behaviour:
- Reset: ROM_CE_N/OE_N/WE_N/BLE_N/BHE_N = 1; ROM_DQ_OE = 0; ROM_A = 0; ROM_DQ_OUT = 0; SNES_DATA_OUT = 0; MCU_DIN = 0; MCU_RDY = 1; pending flags cleared; FSM = IDLE.
- Reset asserted mid-cycle: all strobes deassert asynchronously and the access is abandoned.
- FSM states: IDLE, S_RD, S_WR, M_RD, M_WR, RECOVER.
- Pending latches: SNES_RD_START, SNES_WR_START and accepted MCU requests are latched into pending flags (with address and data), so a pulse is never lost while the FSM is busy.
- Simultaneous SNES_RD_START and SNES_WR_START: the read is kept and the write is discarded.
- A new SNES pulse overwrites a still-pending SNES request.
- Arbitration in IDLE: pending SNES request first, then pending MCU request. An MCU access in progress is never preempted.
- SNES read with SNES_ROM_HIT = 0: pending flag cleared, no SRAM cycle, SNES_DATA_OUT unchanged.
- SNES write with SNES_IS_WRITABLE = 0 or SNES_ROM_HIT = 0: pending flag cleared, no SRAM cycle.
- Read cycle (S_RD/M_RD):
  - On entry: ROM_A loaded, CE_N = 0, OE_N = 0, both lanes enabled, DQ_OE = 0.
  - Held for RD_WAIT cycles. On the last cycle the lane selected by the latched address bit 0 is captured into SNES_DATA_OUT or MCU_DIN.
  - Then RECOVER.
  - SNES latency: SNES_DATA_OUT valid RD_WAIT+2 edges after the start pulse when the FSM was idle.
- Write cycle (S_WR/M_WR), length WR_WAIT+2:
  - Cycle 0: address and data driven, DQ_OE = 1, CE_N = 0, WE_N = 1.
  - Cycles 1..WR_WAIT: WE_N = 0, selected lane enabled only.
  - Final cycle: WE_N = 1, data still driven.
  - Then RECOVER.
- RECOVER: one cycle with all strobes high and DQ_OE = 0 (bus turnaround), then IDLE.
- MCU_RDY:
  - Falls the edge after MCU_RRQ/MCU_WRQ is sampled while MCU_RDY = 1.
  - Rises on the edge that leaves RECOVER after the MCU access; MCU_DIN is valid when it rises.
  - Requests arriving while MCU_RDY = 0 are ignored.
  - MCU_RRQ and MCU_WRQ together: read wins.
- Counter: the single down-counter is loaded on state entry and the state exits at 0. No wrap-around; the counter saturates at 0 in IDLE.

Decomposition:
- Package sram_resp_pkg holds:
  - state enum
  - lane constants LANE_LO = 0, LANE_HI = 1
  - default RD_WAIT/WR_WAIT values
  - function byte_sel(dq16, a0) returning 8 bits
- One sub-module, sram_cycle_timer: loadable down-counter with a done flag. Everything else stays in sram_responder.

Test Plan:
- Read: SRAM model holds word 0x1234 at word 0x000040; SNES_RD_START with SNES_ROM_ADDR = 0x000081, HIT = 1 -> OE_N low for 4 cycles, ROM_A = 0x000040, SNES_DATA_OUT = 0x12 at start+6 edges; address 0x000080 -> 0x34.
- Write gating: SNES_WR_START, addr 0xE00003, data 0xA5, WRITABLE = 1 -> WE_N low 4 cycles, BHE_N = 0, BLE_N = 1, DQ_OUT = 0xA5A5. Repeat with WRITABLE = 0 -> no CE_N/WE_N activity.
- Arbitration: MCU_RRQ at cycle 0, SNES_RD_START at cycle 2 -> MCU read completes uninterrupted, RECOVER, then the SNES read starts. MCU_RDY falls at cycle 1 and rises after the MCU RECOVER.
- Simultaneous SNES_RD_START and SNES_WR_START -> only a read cycle occurs and WE_N stays 1. Second MCU_WRQ while MCU_RDY = 0 -> ignored.
- RST asserted during the WE_N-low phase -> WE_N, CE_N, DQ_OE return to reset values within the same cycle, MCU_RDY = 1, next access starts cleanly.
- Miss: SNES_RD_START with HIT = 0 -> no SRAM strobes, SNES_DATA_OUT unchanged.
